// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Datapath widths and MEM-stage FSM states.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// A bubble clears the control bits and holds the data fields.
import mips_pkg::*;

module mem_wb_reg #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_bubble,
  input  logic              i_ld_en,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [REG_W-1:0]  i_wreg,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_alu,
  output logic [REG_W-1:0]  o_wreg
);

  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu;
  logic [REG_W-1:0]  r_wreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_rdata      <= '0;
      r_alu        <= '0;
      r_wreg       <= '0;
    end else if (i_bubble) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_reg_write  <= i_reg_write;
      r_mem_to_reg <= i_mem_to_reg;
      r_alu        <= i_alu;
      r_wreg       <= i_wreg;
      if (i_ld_en)
        r_rdata <= i_rdata;
    end
  end

  assign o_reg_write  = r_reg_write;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_rdata      = r_rdata;
  assign o_alu        = r_alu;
  assign o_wreg       = r_wreg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage engine: req/ack handshake to data memory,
// stall generation, timeout/misalign error and MEM/WB register.
import mips_pkg::*;

module mem_stage_ctrl #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              mem_err
);

  mem_state_e r_state;
  mem_state_e w_state_nx;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nx;
  logic r_err;

  logic w_memop;
  logic w_mis;
  logic w_req;
  logic w_hit;
  logic w_done;
  logic w_abort;
  logic w_stall;
  logic w_bubble;
  logic w_ld_en;

  assign w_memop = MemtoRegM | MemWriteM;
  assign w_mis   = w_memop & (ALUOutM[1:0] != 2'b00);
  assign w_req   = ~reset & ~w_mis & w_memop;
  assign w_hit   = (r_state == WAIT) &
                   (r_cnt == TO_W'(TIMEOUT - 1));
  assign w_done  = w_req & mem_ack;
  // ack in the last WAIT cycle still counts as completion
  assign w_abort = w_req & ~mem_ack & w_hit;
  assign w_stall = w_req & ~mem_ack & ~w_hit;

  assign w_bubble = w_stall | w_abort | w_mis;
  assign w_ld_en  = w_done & MemtoRegM;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_req && !mem_ack) begin
          w_state_nx = WAIT;
          w_cnt_nx   = '0;
        end
      end
      WAIT: begin
        if (!w_req || mem_ack || w_hit)
          w_state_nx = IDLE;
        else
          w_cnt_nx = r_cnt + 1'b1;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_abort || w_mis)
        r_err <= 1'b1;
    end
  end

  assign mem_req   = w_req;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUOutM[DATA_W-1:2], 2'b00};
  assign mem_wdata = WriteDataM;
  assign StallM    = w_stall;
  assign mem_err   = r_err;

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb (
    .clk         (clk),
    .reset       (reset),
    .i_bubble    (w_bubble),
    .i_ld_en     (w_ld_en),
    .i_reg_write (RegWriteM),
    .i_mem_to_reg(MemtoRegM),
    .i_alu       (ALUOutM),
    .i_wreg      (WriteRegM),
    .i_rdata     (mem_rdata),
    .o_reg_write (RegWriteW),
    .o_mem_to_reg(MemtoRegW),
    .o_rdata     (ReadDataW),
    .o_alu       (ALUOutW),
    .o_wreg      (WriteRegW)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases plus random
// instructions against a transaction-level model.
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        StallM, RegWriteW, MemtoRegW, mem_err;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  mem_stage_ctrl #(.DATA_W(32), .REG_W(5),
                   .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        e_rw, e_m2r, e_err;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic check_w(input string tag);
    check({tag, ".rw"},  {31'd0, RegWriteW}, {31'd0, e_rw});
    check({tag, ".m2r"}, {31'd0, MemtoRegW}, {31'd0, e_m2r});
    check({tag, ".rd"},  ReadDataW, e_rd);
    check({tag, ".alu"}, ALUOutW, e_alu);
    check({tag, ".wr"},  {27'd0, WriteRegW}, {27'd0, e_wr});
    check({tag, ".err"}, {31'd0, mem_err}, {31'd0, e_err});
  endtask

  task automatic model_reset();
    e_rw = 0; e_m2r = 0; e_err = 0;
    e_rd = '0; e_alu = '0; e_wr = '0;
  endtask

  // One instruction held in EX/MEM; memory acks after lat cycles
  // (lat > TO never acks). Expected timing follows from the rules:
  // an aligned access occupies min(lat,TO)+1 cycles, stalling in all
  // but the last.
  task automatic do_instr(input string tag,
                          input logic rw, input logic m2r,
                          input logic mw, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] wr,
                          input int lat, input logic [31:0] rdata);
    bit memop, mis, ok;
    int ncyc;
    memop = m2r | mw;
    mis   = memop && (alu[1:0] != 2'b00);
    if (!memop || mis) ncyc = 1;
    else ncyc = (lat <= TO) ? lat + 1 : TO + 1;
    ok = !memop || (!mis && lat <= TO);
    for (int i = 0; i < ncyc; i++) begin
      bit last;
      last = (i == ncyc - 1);
      RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
      ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
      if (memop && !mis) mem_ack = (i == lat);
      else mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = (i == lat) ? rdata : $urandom;
      #1;
      check({tag, ".req"}, {31'd0, mem_req},
            {31'd0, memop && !mis});
      check({tag, ".stall"}, {31'd0, StallM},
            {31'd0, memop && !mis && !last});
      if (memop && !mis) begin
        check({tag, ".we"}, {31'd0, mem_we}, {31'd0, mw});
        check({tag, ".addr"}, mem_addr, {alu[31:2], 2'b00});
        if (mw) check({tag, ".wdata"}, mem_wdata, wd);
      end
      @(posedge clk); #1;
      if (!last || !ok) begin
        e_rw = 0; e_m2r = 0;
        if (last) e_err = 1;
      end else begin
        e_rw = rw; e_m2r = m2r; e_alu = alu; e_wr = wr;
        if (m2r) e_rd = rdata;
      end
      check_w(tag);
    end
  endtask

  initial begin
    reset = 1; mem_ack = 0; mem_rdata = '0;
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
    check_w("reset");

    do_instr("alu", 1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    do_instr("ld3", 1, 1, 0, 32'h40, 32'h0, 5'd7, 3,
             32'hDEADBEEF);
    do_instr("st0", 0, 0, 1, 32'h80, 32'hCAFEF00D, 5'd0, 0,
             32'h0);
    do_instr("ldto", 1, 1, 0, 32'h44, 32'h0, 5'd9, 99,
             32'h0);
    do_instr("after", 1, 0, 0, 32'h55, 32'h0, 5'd3, 0, 32'h0);
    do_instr("ldmis", 1, 1, 0, 32'h42, 32'h0, 5'd4, 0,
             32'h0);
    do_instr("ldedge", 1, 1, 0, 32'h48, 32'h0, 5'd6, TO,
             32'h0BADF00D);

    // reset in WAIT cycle 2 abandons the access
    do_instr("ld_pre", 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
    ALUOutM = 32'h60; WriteRegM = 5'd8; mem_ack = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    reset = 1; #1;
    check("rst.req", {31'd0, mem_req}, 32'd0);
    check("rst.stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    check_w("rst");
    RegWriteM = 0; MemtoRegM = 0; ALUOutM = '0;
    WriteRegM = '0; mem_ack = 1; mem_rdata = 32'h11111111;
    #1;
    check("stray.req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    check_w("stray");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int k;
      logic m2r, mw;
      k = $urandom_range(0, 2);
      m2r = (k == 1);
      mw  = (k == 2);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      do_instr("rnd", 1'($urandom_range(0, 1)), m2r, mw, a,
               $urandom, 5'($urandom), $urandom_range(0, TO + 2),
               $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
